// File: rtl/bytecode_prefetch.sv
// Bytecode prefetcher: fetches 32-bit big-endian words into a circular byte
// buffer and presents one byte per pop, tracking the JVM byte PC.
module bytecode_prefetch #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        iram_data,
  output logic              waiting,
  input  logic              byte_take,
  output logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t            state_q;
  logic [7:0]        buf_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [WA_W-1:0]   fetch_adr_q;
  logic [1:0]        skip_q;

  logic              push_en;
  logic [2:0]        push_n;
  logic              pop;
  logic [CNT_W-1:0]  space;

  // Per-cycle push/pop decisions; a redirect suppresses both.
  always_comb begin
    push_en = (state_q == S_REQ) && mem_ack && !redirect;
    push_n  = push_en ? (3'd4 - {1'b0, skip_q}) : 3'd0;
    pop     = byte_take && (count_q != '0) && !redirect;
    space   = CNT_W'(DEPTH) - count_q;
  end

  // Byte lanes skip..3 of the returned word land at consecutive tail slots.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_en && (i >= int'(skip_q)))
        buf_q[tail_q + PTR_W'(i) - PTR_W'(skip_q)] <= mem_rdata[31-8*i -: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fetch_adr_q <= '0;
      skip_q      <= '0;
      pc          <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
    end else if (redirect) begin
      count_q     <= '0;
      head_q      <= tail_q;
      pc          <= redirect_pc;
      fetch_adr_q <= redirect_pc[ADDR_W-1:2];
      skip_q      <= redirect_pc[1:0];
      // An outstanding request must still complete; its data is stale.
      if (state_q != S_IDLE && mem_ack) begin
        state_q <= S_IDLE;
        mem_rd  <= 1'b0;
      end else if (state_q == S_REQ) begin
        state_q <= S_DROP;
      end
    end else begin
      count_q <= count_q + CNT_W'(push_n) - CNT_W'(pop);
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
        pc     <= pc + ADDR_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (space >= CNT_W'(4)) begin
            state_q  <= S_REQ;
            mem_rd   <= 1'b1;
            mem_addr <= fetch_adr_q;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            tail_q      <= tail_q + PTR_W'(push_n);
            skip_q      <= '0;
            fetch_adr_q <= fetch_adr_q + WA_W'(1);
            mem_rd      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_DROP: begin
          if (mem_ack) begin
            mem_rd  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign waiting   = (count_q == '0);
  assign iram_data = waiting ? 8'h00 : buf_q[head_q];

endmodule

// File: tb/tb_bytecode_prefetch.sv
// Bench for bytecode_prefetch: memory responder plus a byte-stream model
// (the byte at pc must always equal memory[pc]).
module tb_bytecode_prefetch;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              mem_rd;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic [7:0]        iram_data;
  logic              waiting;
  logic              byte_take = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;

  always #5 clk = ~clk;

  bytecode_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .iram_data(iram_data), .waiting(waiting), .byte_take(byte_take),
    .pc(pc), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  logic [31:0] mem [16384];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] pc_model = '0;
  int          busy = 0, left = 0, wait_n = 0, req_count = 0;
  bit          rand_waits = 0, force_ack = 0, prev_ack = 0;
  logic [13:0] req_addr = '0;

  function automatic logic [7:0] byte_at(input logic [15:0] a);
    logic [31:0] w;
    w = mem[a[15:2]];
    case (a[1:0])
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: respond to memory, advance the model, then check at the negedge.
  task automatic tick();
    if (prev_ack) chk("rd_gap", 32'(mem_rd), 0);
    prev_ack = 0;
    if (force_ack) begin
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; busy = 0;
    end else if (mem_rd) begin
      if (busy == 0) begin
        busy = 1;
        left = rand_waits ? int'($urandom_range(0, 3)) : wait_n;
        req_addr = mem_addr;
        req_count++;
      end else begin
        chk("addr_stable", 32'(mem_addr), 32'(req_addr));
      end
      if (left == 0) begin
        mem_ack = 1'b1; mem_rdata = mem[mem_addr]; busy = 0; prev_ack = 1;
      end else begin
        mem_ack = 1'b0; left--;
      end
    end else begin
      mem_ack = 1'b0; busy = 0;
    end
    if (!reset) pc_model = '0;
    else if (redirect) pc_model = redirect_pc;
    else if (byte_take && !waiting) pc_model++;
    @(negedge clk);
    chk("pc", 32'(pc), 32'(pc_model));
    if (waiting) chk("empty_data", 32'(iram_data), 0);
    else chk("data", 32'(iram_data), 32'(byte_at(pc_model)));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"}, 32'(mem_rd), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_data"}, 32'(iram_data), 0);
    chk({tag, "_wait"}, 32'(waiting), 1);
    chk({tag, "_pc"}, 32'(pc), 0);
  endtask

  initial begin
    int          hi;
    int          rq0;
    logic [15:0] pcb;
    logic [31:0] w;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[0] = 32'h10203040;
    mem[1] = 32'h50607080;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");

    // Reset release then stream with take held high
    reset = 1'b1; byte_take = 1'b1;
    tick();
    chk("startup_rd", 32'(mem_rd), 1);
    chk("startup_addr", 32'(mem_addr), 0);
    chk("startup_wait", 32'(waiting), 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("stream_data", 32'(iram_data), 32'(16 * (i + 1)));
      chk("stream_pc", 32'(pc), 32'(i));
      chk("stream_wait", 32'(waiting), 0);
      tick();
    end
    byte_take = 1'b0;
    repeat (12) tick();
    chk("fill_idle", 32'(mem_rd), 0);

    // Unaligned redirect from IDLE
    mem[1] = 32'hAABBCCDD; mem[2] = 32'h11223344;
    redirect = 1'b1; redirect_pc = 16'h0006;
    tick();
    redirect = 1'b0;
    chk("unal_wait", 32'(waiting), 1);
    chk("unal_rd_low", 32'(mem_rd), 0);
    tick();
    chk("unal_rd1", 32'(mem_rd), 1);
    chk("unal_addr1", 32'(mem_addr), 1);
    tick();
    chk("unal_b0", 32'(iram_data), 32'hCC);
    byte_take = 1'b1;
    tick();
    chk("unal_addr2", 32'(mem_addr), 2);
    chk("unal_b1", 32'(iram_data), 32'hDD);
    tick();
    chk("unal_b2", 32'(iram_data), 32'h11);
    chk("unal_pc8", 32'(pc), 8);
    byte_take = 1'b0;

    // Redirect while the word-3 request waits 5 cycles
    wait_n = 5;
    tick();
    chk("drop_rd", 32'(mem_rd), 1);
    chk("drop_addr", 32'(mem_addr), 3);
    redirect = 1'b1; redirect_pc = 16'h0100; byte_take = 1'b1;
    tick();
    redirect = 1'b0;
    chk("drop_wait", 32'(waiting), 1);
    hi = 0;
    for (int k = 0; k < 20 && mem_rd; k++) begin
      chk("drop_hold_addr", 32'(mem_addr), 3);
      hi++;
      tick();
    end
    chk("drop_rd_fell", 32'(mem_rd), 0);
    chk("drop_hi_cycles", 32'(hi), 5);
    chk("drop_nodata", 32'(waiting), 1);
    chk("take_ignored_pc", 32'(pc), 32'h100);
    wait_n = 0;
    tick();
    chk("refetch_rd", 32'(mem_rd), 1);
    chk("refetch_addr", 32'(mem_addr), 32'h40);
    tick();
    w = mem[64];
    chk("refetch_b0", 32'(iram_data), 32'(w[31:24]));
    chk("refetch_pc", 32'(pc), 32'h100);
    byte_take = 1'b0;

    // Full buffer: two requests from empty, then silent until space 4
    repeat (10) tick();
    chk("pre_full_idle", 32'(mem_rd), 0);
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    rq0 = req_count;
    repeat (12) tick();
    chk("full_reqs", 32'(req_count - rq0), 2);
    chk("full_rd", 32'(mem_rd), 0);
    byte_take = 1'b1; tick(); byte_take = 1'b0;
    repeat (3) tick();
    chk("space1_rd", 32'(mem_rd), 0);
    chk("space1_reqs", 32'(req_count - rq0), 2);
    byte_take = 1'b1; repeat (3) tick(); byte_take = 1'b0;
    chk("space3_rd", 32'(mem_rd), 0);
    tick();
    chk("space4_rd", 32'(mem_rd), 1);

    // Ack and take on the same edge with count 4
    pcb = pc;
    byte_take = 1'b1;
    tick();
    chk("sim_pc", 32'(pc), 32'(pcb + 16'd1));
    byte_take = 1'b1; repeat (2) tick(); byte_take = 1'b0;
    wait_n = 5;
    tick();
    chk("cnt7_a", 32'(mem_rd), 0);
    byte_take = 1'b1; tick(); byte_take = 1'b0;
    chk("cnt7_b", 32'(mem_rd), 0);
    tick();
    chk("cnt7_c", 32'(mem_rd), 1);

    // Reset in the middle of a request, with late acks
    reset = 1'b0; pc_model = '0;
    #1;
    chk_reset_vals("midrst");
    tick();
    force_ack = 1; tick(); force_ack = 0;
    chk("rst_ack_ign", 32'(waiting), 1);
    reset = 1'b1; force_ack = 1; tick(); force_ack = 0;
    chk("rst_refetch_rd", 32'(mem_rd), 1);
    chk("rst_refetch_addr", 32'(mem_addr), 0);
    chk("rst_late_ack_wait", 32'(waiting), 1);
    wait_n = 0;
    tick();
    chk("rst_b0", 32'(iram_data), 32'h10);
    chk("rst_b0_wait", 32'(waiting), 0);

    // Random traffic against the byte-stream model
    rand_waits = 1;
    for (int c = 0; c < 3000; c++) begin
      byte_take   = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 63) == 0);
      redirect_pc = 16'($urandom);
      tick();
    end
    redirect = 1'b0; byte_take = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
